// File: rtl/apb_fifo_port_pkg.sv
// Shared definitions for the APB front-end of the sync FIFO: register offsets,
// CTRL/IRQ_STAT bit positions and the bus FSM encoding.
package apb_fifo_port_pkg;

    localparam logic [31:0] OFF_DATA   = 32'h00;
    localparam logic [31:0] OFF_STATUS = 32'h04;
    localparam logic [31:0] OFF_CTRL   = 32'h08;
    localparam logic [31:0] OFF_THRESH = 32'h0C;
    localparam logic [31:0] OFF_IRQ    = 32'h10;

    localparam int CTRL_BLOCK  = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_OVF   = 1;
    localparam int IRQ_UDF   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/apb_fifo_port_irq.sv
// Sticky IRQ_STAT register (set beats write-one-to-clear) and the registered irq line.
module apb_fifo_irq
    import apb_fifo_port_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       levelHit_i,
    input  logic       setOvf_i,
    input  logic       setUdf_i,
    input  logic       clrEn_i,
    input  logic [2:0] clrMask_i,
    input  logic       irqEn_i,
    output logic [2:0] irqStat_o,
    output logic       irq_o
);

    logic [2:0] stat_q;
    logic [2:0] stat_d;
    logic [2:0] setVec;
    logic       irq_q;

    // Clear first, then OR in this cycle's events so a coincident set survives.
    always_comb begin
        setVec            = '0;
        setVec[IRQ_LEVEL] = levelHit_i;
        setVec[IRQ_OVF]   = setOvf_i;
        setVec[IRQ_UDF]   = setUdf_i;
        stat_d            = stat_q;
        if (clrEn_i) begin
            stat_d = stat_d & ~clrMask_i;
        end
        stat_d = stat_d | setVec;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            stat_q <= stat_d;
            irq_q  <= irqEn_i & (|stat_q);
        end
    end

    assign irqStat_o = stat_q;
    assign irq_o     = irq_q;

endmodule

// File: rtl/apb_fifo_port.sv
// APB3 slave front-end for one sync FIFO: DATA push/pop, STATUS, CTRL, THRESH and
// sticky IRQ_STAT registers, with optional stalling on full/empty bounded by TIMEOUT.
module apb_fifo_port
    import apb_fifo_port_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
    parameter int          TIMEOUT   = 255,
    localparam int         LVL_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    input  logic [LVL_W-1:0]  fifo_level,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_en,
    output logic              irq
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t             state_q;
    logic [CNT_W-1:0]   stallCnt_q;
    logic [1:0]         ctrl_q;
    logic [LVL_W-1:0]   thresh_q;
    logic [2:0]         irqStat;

    logic [31:0]        off;
    logic               isData, isCtrl, isThresh, isIrq;
    logic               addrErr, blocked;
    logic               accessStart, stallLive, canStall, timeoutHit;
    logic               okAccess, blockFail, errAccess, goResp;
    logic [31:0]        rdMux;
    logic [LVL_W-1:0]   thrIn, thrClip;
    logic               unusedBits;

    assign off      = paddr - BASE_ADDR;
    assign isData   = (off == OFF_DATA);
    assign isCtrl   = (off == OFF_CTRL);
    assign isThresh = (off == OFF_THRESH);
    assign isIrq    = (off == OFF_IRQ);
    assign addrErr  = (paddr[1:0] != 2'b00) || (off > OFF_IRQ) || (pwrite && (off == OFF_STATUS));
    assign blocked  = isData && !addrErr && (pwrite ? fifo_full : fifo_empty);

    // A stalled access is re-evaluated every cycle while the master keeps it selected.
    assign accessStart = (state_q == ST_IDLE) && psel && penable;
    assign stallLive   = (state_q == ST_STALL) && psel;
    assign canStall    = ctrl_q[CTRL_BLOCK] && (TIMEOUT > 0);
    assign timeoutHit  = (TIMEOUT > 0) && (stallCnt_q == CNT_W'(TIMEOUT - 1));
    assign okAccess    = (accessStart || stallLive) && !addrErr && !blocked;
    assign blockFail   = blocked && ((accessStart && !canStall) || (stallLive && timeoutHit));
    assign errAccess   = (accessStart && addrErr) || blockFail;
    assign goResp      = okAccess || errAccess;

    assign thrIn   = pwdata[LVL_W-1:0];
    assign thrClip = (thrIn > LVL_W'(DEPTH)) ? LVL_W'(DEPTH) : thrIn;

    assign unusedBits = ^pwdata;

    always_comb begin
        rdMux = '0;
        case (off)
            OFF_DATA:   rdMux = 32'(fifo_rdata);
            OFF_STATUS: rdMux = 32'({fifo_level, fifo_full, fifo_empty});
            OFF_CTRL:   rdMux = 32'(ctrl_q);
            OFF_THRESH: rdMux = 32'(thresh_q);
            OFF_IRQ:    rdMux = 32'(irqStat);
            default:    rdMux = '0;
        endcase
    end

    // Bus FSM; every response output is zero except in the single RESP cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            stallCnt_q <= '0;
            pready     <= 1'b0;
            pslverr    <= 1'b0;
            prdata     <= '0;
            wr_en      <= 1'b0;
            wr_data    <= '0;
            rd_en      <= 1'b0;
        end else begin
            pready  <= goResp;
            pslverr <= errAccess;
            prdata  <= (okAccess && !pwrite) ? rdMux : '0;
            wr_en   <= okAccess && pwrite && isData;
            wr_data <= (okAccess && pwrite && isData) ? pwdata[DATA_W-1:0] : '0;
            rd_en   <= okAccess && !pwrite && isData;
            case (state_q)
                ST_IDLE: begin
                    if (goResp) begin
                        state_q <= ST_RESP;
                    end else if (accessStart) begin
                        state_q    <= ST_STALL;
                        stallCnt_q <= '0;
                    end
                end
                ST_STALL: begin
                    if (!psel) begin
                        state_q    <= ST_IDLE;
                        stallCnt_q <= '0;
                    end else if (goResp) begin
                        state_q    <= ST_RESP;
                        stallCnt_q <= '0;
                    end else begin
                        stallCnt_q <= stallCnt_q + 1'b1;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= '0;
            thresh_q <= LVL_W'(DEPTH);
        end else begin
            if (okAccess && pwrite && isCtrl) begin
                ctrl_q <= pwdata[1:0];
            end
            if (okAccess && pwrite && isThresh) begin
                thresh_q <= thrClip;
            end
        end
    end

    apb_fifo_irq uIrq (
        .clk_i      (clk),
        .rst_i      (rst),
        .levelHit_i (fifo_level >= thresh_q),
        .setOvf_i   (blockFail && pwrite),
        .setUdf_i   (blockFail && !pwrite),
        .clrEn_i    (okAccess && pwrite && isIrq),
        .clrMask_i  (pwdata[2:0]),
        .irqEn_i    (ctrl_q[CTRL_IRQ_EN]),
        .irqStat_o  (irqStat),
        .irq_o      (irq)
    );

endmodule

// File: tb/tb_apb_fifo_port.sv
// Directed bench for apb_fifo_port: APB accesses against hand-computed register,
// strobe, wait-state and interrupt expectations with the FIFO side driven directly.
module tb_apb_fifo_port;

    localparam logic [31:0] BASE = 32'h2000_0000;

    logic        clk;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;
    logic        fifo_full, fifo_empty;
    logic [4:0]  fifo_level;
    logic [31:0] fifo_rdata;
    logic        wr_en, rd_en, irq;
    logic [31:0] wr_data;

    int          checkCount = 0;
    int          failCount  = 0;

    logic [31:0] resRdata, resWrData;
    logic        resErr, resRdAtReady;
    int          resWaits, resWrCnt, resRdCnt;

    apb_fifo_port dut (
        .clk        (clk),
        .rst        (rst),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_level (fifo_level),
        .fifo_rdata (fifo_rdata),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One APB transfer; dropFullAt>0 clears fifo_full at that ACCESS cycle.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                                 input int dropFullAt);
        int  cyc;
        bit  done;
        resWaits = 0; resWrCnt = 0; resRdCnt = 0; resRdAtReady = 0;
        resRdata = '0; resErr = 0; resWrData = '0;
        done = 0;
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = data;
        @(posedge clk); #1;
        penable = 1;
        cyc = 1;
        while (!done && resWaits < 400) begin
            if (dropFullAt != 0 && cyc == dropFullAt) fifo_full = 0;
            if (wr_en) begin resWrCnt++; resWrData = wr_data; end
            if (rd_en) resRdCnt++;
            if (pready) begin
                resRdata = prdata; resErr = pslverr; resRdAtReady = rd_en;
                done = 1;
            end else begin
                resWaits++;
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!done) checkOutput("bus_timeout", 32'(resWaits), 32'd0);
        @(posedge clk); #1;
        psel = 0; penable = 0;
        if (wr_en) resWrCnt++;
        if (rd_en) resRdCnt++;
    endtask

    initial begin
        rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        fifo_full = 0; fifo_empty = 1; fifo_level = 0; fifo_rdata = '0;
        repeat (3) @(posedge clk); #1;
        checkOutput("rst_ctl_outs", 32'({pready, pslverr, wr_en, rd_en, irq}), 32'd0);
        checkOutput("rst_prdata", prdata, 32'd0);
        rst = 0;

        applyStimulus(0, BASE + 32'h04, 0, 0); checkOutput("rst_status", resRdata, 32'h1);
        applyStimulus(0, BASE + 32'h08, 0, 0); checkOutput("rst_ctrl", resRdata, 32'h0);
        applyStimulus(0, BASE + 32'h0C, 0, 0); checkOutput("rst_thresh", resRdata, 32'd16);
        applyStimulus(0, BASE + 32'h10, 0, 0); checkOutput("rst_irqstat", resRdata, 32'h0);

        // T1: push on empty FIFO, one wait state.
        applyStimulus(1, BASE, 32'hA5, 0);
        checkOutput("t1_waits", 32'(resWaits), 32'd1);
        checkOutput("t1_err", 32'(resErr), 32'd0);
        checkOutput("t1_wrcnt", 32'(resWrCnt), 32'd1);
        checkOutput("t1_wrdata", resWrData, 32'hA5);
        checkOutput("t1_rdcnt", 32'(resRdCnt), 32'd0);

        // T2: pop with data, then pop on empty with CTRL=0.
        fifo_empty = 0; fifo_level = 1; fifo_rdata = 32'h3C;
        applyStimulus(0, BASE, 0, 0);
        checkOutput("t2_prdata", resRdata, 32'h3C);
        checkOutput("t2_err", 32'(resErr), 32'd0);
        checkOutput("t2_rdcnt", 32'(resRdCnt), 32'd1);
        checkOutput("t2_rd_at_ready", 32'(resRdAtReady), 32'd1);
        fifo_empty = 1; fifo_level = 0; fifo_rdata = 32'h99;
        applyStimulus(0, BASE, 0, 0);
        checkOutput("t2_udf_err", 32'(resErr), 32'd1);
        checkOutput("t2_udf_prdata", resRdata, 32'd0);
        checkOutput("t2_udf_rdcnt", 32'(resRdCnt), 32'd0);
        checkOutput("t2_udf_waits", 32'(resWaits), 32'd1);
        applyStimulus(0, BASE + 32'h10, 0, 0); checkOutput("t2_irqstat", resRdata, 32'h4);
        applyStimulus(1, BASE + 32'h10, 32'h7, 0);
        applyStimulus(0, BASE + 32'h10, 0, 0); checkOutput("clr_irqstat", resRdata, 32'h0);

        // T3: full held through SETUP + 4 ACCESS cycles, dropped in ACCESS 5,
        // so pready shows up in ACCESS 6 (5 wait states).
        applyStimulus(1, BASE + 32'h08, 32'h1, 0);
        fifo_full = 1; fifo_empty = 0;
        applyStimulus(1, BASE, 32'h1234, 5);
        checkOutput("t3_waits", 32'(resWaits), 32'd5);
        checkOutput("t3_err", 32'(resErr), 32'd0);
        checkOutput("t3_wrcnt", 32'(resWrCnt), 32'd1);
        checkOutput("t3_wrdata", resWrData, 32'h1234);

        // T4: full never drops; 1 evaluate cycle + 255 stall cycles of wait.
        fifo_full = 1;
        applyStimulus(1, BASE, 32'hDEAD, 0);
        checkOutput("t4_waits", 32'(resWaits), 32'd256);
        checkOutput("t4_err", 32'(resErr), 32'd1);
        checkOutput("t4_wrcnt", 32'(resWrCnt), 32'd0);
        fifo_full = 0;
        applyStimulus(0, BASE + 32'h10, 0, 0); checkOutput("t4_irqstat", resRdata, 32'h2);

        // T5: level threshold interrupt and set-over-clear.
        applyStimulus(1, BASE + 32'h10, 32'h7, 0);
        applyStimulus(1, BASE + 32'h0C, 32'h4, 0);
        applyStimulus(1, BASE + 32'h08, 32'h2, 0);
        fifo_level = 3;
        repeat (3) @(posedge clk); #1;
        checkOutput("t5_irq_below", 32'(irq), 32'd0);
        fifo_level = 4;
        repeat (3) @(posedge clk); #1;
        checkOutput("t5_irq_at", 32'(irq), 32'd1);
        applyStimulus(0, BASE + 32'h10, 0, 0); checkOutput("t5_irqstat", resRdata, 32'h1);
        applyStimulus(0, BASE + 32'h04, 0, 0); checkOutput("t5_status", resRdata, 32'h10);
        applyStimulus(1, BASE + 32'h10, 32'h1, 0);
        applyStimulus(0, BASE + 32'h10, 0, 0); checkOutput("t5_set_wins", resRdata, 32'h1);
        fifo_level = 3;
        applyStimulus(1, BASE + 32'h10, 32'h1, 0);
        repeat (2) @(posedge clk); #1;
        checkOutput("t5_irq_cleared", 32'(irq), 32'd0);
        applyStimulus(0, BASE + 32'h10, 0, 0); checkOutput("t5_irqstat_clr", resRdata, 32'h0);

        // THRESH clipping and in-range write bits.
        applyStimulus(1, BASE + 32'h0C, 32'hFFFF_FFFF, 0);
        applyStimulus(0, BASE + 32'h0C, 0, 0); checkOutput("thresh_clip", resRdata, 32'd16);
        applyStimulus(1, BASE + 32'h0C, 32'h21, 0);
        applyStimulus(0, BASE + 32'h0C, 0, 0); checkOutput("thresh_bits", resRdata, 32'd1);
        applyStimulus(1, BASE + 32'h08, 32'hFFFF_FFFE, 0);
        applyStimulus(0, BASE + 32'h08, 0, 0); checkOutput("ctrl_bits", resRdata, 32'h2);
        applyStimulus(1, BASE + 32'h0C, 32'd16, 0);

        // T6: decode errors have no side effects.
        fifo_empty = 0;
        applyStimulus(0, BASE + 32'h02, 0, 0);
        checkOutput("t6_unal_err", 32'(resErr), 32'd1);
        checkOutput("t6_unal_prdata", resRdata, 32'd0);
        checkOutput("t6_unal_strobes", 32'(resWrCnt + resRdCnt), 32'd0);
        applyStimulus(0, BASE + 32'h14, 0, 0);
        checkOutput("t6_unmap_err", 32'(resErr), 32'd1);
        checkOutput("t6_unmap_prdata", resRdata, 32'd0);
        applyStimulus(1, BASE + 32'h04, 32'hFF, 0);
        checkOutput("t6_status_wr_err", 32'(resErr), 32'd1);
        checkOutput("t6_status_wr_strobe", 32'(resWrCnt), 32'd0);

        // Reset while stalled on a full FIFO.
        applyStimulus(1, BASE + 32'h08, 32'h1, 0);
        fifo_full = 1;
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = 1; paddr = BASE; pwdata = 32'h77;
        @(posedge clk); #1;
        penable = 1;
        repeat (10) @(posedge clk); #1;
        checkOutput("stall_pready_low", 32'(pready), 32'd0);
        rst = 1; #1;
        checkOutput("rst_mid_outs", 32'({pready, pslverr, wr_en, rd_en, irq}), 32'd0);
        checkOutput("rst_mid_prdata", prdata, 32'd0);
        psel = 0; penable = 0; fifo_full = 0;
        @(posedge clk); #1;
        rst = 0;
        repeat (2) @(posedge clk); #1;
        checkOutput("post_rst_wr_en", 32'(wr_en), 32'd0);
        applyStimulus(0, BASE + 32'h08, 0, 0); checkOutput("post_rst_ctrl", resRdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
